// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer stimulus front end.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LIT  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Width of the delay counter: holds DELAY_MIN plus the largest random extra.
  function automatic int delay_width(input int dmin, input int bits);
    int w;
    w = $clog2(dmin + (1 << bits));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces a bouncy active-high button; emits a one-cycle
// press pulse on each accepted 0->1 transition of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic button_raw,
  output logic db_level,
  output logic press
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      db_level  <= 1'b0;
      press     <= 1'b0;
    end else if (ena) begin
      sync1_reg <= button_raw;
      sync2_reg <= sync1_reg;
      press     <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2_reg == db_level) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE)) begin
        db_level <= sync2_reg;
        cnt_reg  <= '0;
        press    <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-timer stimulus: random delay, LED, press/false-start/timeout detection.
// Optional REACTION_LFSR_EN adds a 16-bit Galois LFSR for the random delay.
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int PRESCALE         = 1000,
  parameter int DELAY_MIN        = 500,
  parameter int DELAY_RANGE_BITS = 10,
  parameter int TIMEOUT_TICKS    = 2000,
  parameter int DEBOUNCE         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  input  logic button_raw,
  output logic led_on,
  output logic stim_start,
  output logic resp,
  output logic false_start,
  output logic timeout,
  output logic busy
);

  localparam int DW = delay_width(DELAY_MIN, DELAY_RANGE_BITS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state_reg;
  logic [DW-1:0] delay_reg;
  logic [DW-1:0] delay_load;
  logic [PW-1:0] presc_reg;
  logic [TW-1:0] lit_cnt_reg;
  logic          tick;
  logic          db_level;
  logic          press;
  logic          press_ok;

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .button_raw(button_raw),
    .db_level  (db_level),
    .press     (press)
  );

  assign press_ok = press & db_level;
  assign tick     = (presc_reg == PW'(PRESCALE - 1));

`ifdef REACTION_LFSR_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else if (ena) begin
      lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign delay_load = DW'(DELAY_MIN) + DW'(lfsr_reg[DELAY_RANGE_BITS-1:0]);
`else
  assign delay_load = DW'(DELAY_MIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      delay_reg   <= '0;
      presc_reg   <= '0;
      lit_cnt_reg <= '0;
      led_on      <= 1'b0;
      stim_start  <= 1'b0;
      resp        <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else if (ena) begin
      stim_start <= 1'b0;
      resp       <= 1'b0;

      // Prescaler phase is anchored to the accepted start.
      if (state_reg == IDLE && start) begin
        presc_reg <= '0;
      end else if (tick) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            delay_reg   <= delay_load;
            lit_cnt_reg <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // A press is checked first so one landing on the final tick is a false start.
          if (press_ok) begin
            false_start <= 1'b1;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end else if (delay_reg == '0) begin
            led_on     <= 1'b1;
            stim_start <= 1'b1;
            state_reg  <= LIT;
          end else if (tick) begin
            delay_reg <= delay_reg - 1'b1;
          end
        end
        LIT: begin
          if (press_ok) begin
            resp      <= 1'b1;
            led_on    <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (lit_cnt_reg == TW'(TIMEOUT_TICKS)) begin
            timeout   <= 1'b1;
            led_on    <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else if (tick) begin
            lit_cnt_reg <= lit_cnt_reg + 1'b1;
          end
        end
        default: begin
          led_on    <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus: table of trials, random trials
// against an arithmetic outcome model, plus enable-hold and async-reset cases.
module tb_reaction_stimulus;

  localparam int P      = 4;
  localparam int DMIN   = 3;
  localparam int DB     = 2;
  localparam int TO     = 5;
  localparam int LED_AT = DMIN * P + 1;
  localparam int TO_AT  = LED_AT + TO * P;

  localparam int K_RESP  = 0;
  localparam int K_FALSE = 1;
  localparam int K_TO    = 2;

  typedef struct {
    int pre_held;
    int rel_at;
    int press_at;
    int glitch_at;
    int exp_kind;
    int exp_at;
  } trial_t;

  logic clk = 1'b0;
  logic rst_n, ena, start, button_raw;
  logic led_on, stim_start, resp, false_start, timeout, busy;

  int errors = 0;
  int checks = 0;

  reaction_stimulus #(
    .PRESCALE        (P),
    .DELAY_MIN       (DMIN),
    .DELAY_RANGE_BITS(10),
    .TIMEOUT_TICKS   (TO),
    .DEBOUNCE        (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .button_raw (button_raw),
    .led_on     (led_on),
    .stim_start (stim_start),
    .resp       (resp),
    .false_start(false_start),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outcome model: a press sampled at edge p is seen by the controller DB+3
  // edges later; the LED lights at LED_AT and times out at TO_AT.
  task automatic model(input int press_at, output int kind, output int at);
    int d;
    if (press_at < 0) begin
      kind = K_TO; at = TO_AT;
    end else begin
      d = press_at + DB + 3;
      if (d <= LED_AT) begin
        kind = K_FALSE; at = d;
      end else if (d <= TO_AT) begin
        kind = K_RESP; at = d;
      end else begin
        kind = K_TO; at = TO_AT;
      end
    end
  endtask

  function automatic logic btn(input trial_t t, input int k);
    logic b;
    b = 1'b0;
    if (t.pre_held != 0 && k < t.rel_at) b = 1'b1;
    if (t.press_at >= 0 && k >= t.press_at) b = 1'b1;
    if (k == t.glitch_at) b = 1'b1;
    return b;
  endfunction

  task automatic run_trial(input trial_t t, input int idx);
    int kind, at, stim_first, stim_cnt;
    button_raw = (t.pre_held != 0);
    repeat (12) step();
    start = 1'b1;
    button_raw = btn(t, 0);
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_led", led_on, 0);
    chk("start_false_clr", false_start, 0);
    chk("start_timeout_clr", timeout, 0);
    kind = -1; at = -1; stim_first = -1; stim_cnt = 0;
    for (int k = 1; k <= 60 && kind < 0; k++) begin
      button_raw = btn(t, k);
      step();
      if (stim_start) begin
        stim_cnt++;
        if (stim_first < 0) stim_first = k;
      end
      if (resp) kind = K_RESP;
      else if (false_start) kind = K_FALSE;
      else if (timeout) kind = K_TO;
      if (kind >= 0) at = k;
    end
    chk("outcome_kind", kind, t.exp_kind);
    chk("outcome_cycle", at, t.exp_at);
    chk("end_led", led_on, 0);
    chk("end_busy", busy, 0);
    chk("stim_cycle", stim_first, (t.exp_kind == K_FALSE) ? -1 : LED_AT);
    chk("stim_width", stim_cnt, (t.exp_kind == K_FALSE) ? 0 : 1);
    chk("flag_false", false_start, (t.exp_kind == K_FALSE) ? 1 : 0);
    chk("flag_timeout", timeout, (t.exp_kind == K_TO) ? 1 : 0);
    button_raw = 1'b0;
    step();
    chk("resp_width", resp, 0);
    $display("trial %0d: press_at=%0d glitch_at=%0d kind=%0d at=%0d", idx, t.press_at, t.glitch_at, kind, at);
  endtask

`ifdef REACTION_LFSR_EN
  int dl[2][3];

  task automatic lfsr_run(input int run);
    int k;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (k = 1; k <= 5000; k++) begin
        step();
        if (led_on) break;
      end
      dl[run][i] = (k - 1) / P;
      chk("lfsr_delay_range", (dl[run][i] >= 3 && dl[run][i] <= 1026) ? 1 : 0, 1);
      $display("lfsr run %0d delay %0d: %0d ticks", run, i, dl[run][i]);
      for (int w = 0; w < 40 && busy; w++) step();
    end
  endtask
`endif

  trial_t tbl[10];

  initial begin
    trial_t rt;
    int kind, at, found, p;

    tbl[0] = '{0, 0,  -1, -1, K_TO,    33};
    tbl[1] = '{0, 0,   9, -1, K_RESP,  14};
    tbl[2] = '{0, 0,   2, -1, K_FALSE,  7};
    tbl[3] = '{0, 0,   8, -1, K_FALSE, 13};
    tbl[4] = '{0, 0,  28, -1, K_RESP,  33};
    tbl[5] = '{0, 0,  29, -1, K_TO,    33};
    tbl[6] = '{0, 0,  -1, 20, K_TO,    33};
    tbl[7] = '{1, 100, -1, -1, K_TO,   33};
    tbl[8] = '{1, 1,   7, -1, K_FALSE, 12};
    tbl[9] = '{0, 0,  15, -1, K_RESP,  20};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; button_raw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_led", led_on, 0);
    chk("reset_stim", stim_start, 0);
    chk("reset_resp", resp, 0);
    chk("reset_false", false_start, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    step();

`ifdef REACTION_LFSR_EN
    lfsr_run(0);
    lfsr_run(1);
    for (int i = 0; i < 3; i++) chk("lfsr_repeatable", dl[1][i], dl[0][i]);
`else
    for (int i = 0; i < 10; i++) run_trial(tbl[i], i);

    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(1, 40);
      rt.pre_held = 0;
      rt.rel_at = 0;
      rt.press_at = p;
      rt.glitch_at = (p > 4 && $urandom_range(0, 1) == 1) ? p - 3 : -1;
      model(p, kind, at);
      rt.exp_kind = kind;
      rt.exp_at = at;
      run_trial(rt, 100 + i);
    end

    // Enable held low for 10 cycles right after start delays the LED by 10.
    repeat (12) step();
    start = 1'b1;
    step();
    start = 1'b0;
    ena = 1'b0;
    repeat (10) step();
    ena = 1'b1;
    found = -1;
    for (int k = 11; k <= 60 && found < 0; k++) begin
      step();
      if (led_on) found = k;
    end
    chk("ena_hold_led_cycle", found, LED_AT + 10);
    $display("ena hold: led at %0d", found);
    for (int w = 0; w < 40 && busy; w++) step();

    // Asynchronous reset while the LED is lit.
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    chk("pre_reset_led", led_on, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", led_on, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_stim", stim_start, 0);
    chk("async_reset_resp", resp, 0);
    chk("async_reset_flags", {30'd0, false_start, timeout}, 0);
    $display("async reset during LIT: led=%0d busy=%0d", led_on, busy);
    @(negedge clk);
    rst_n = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
